multi_cycle_control: RTL and testbench

Parametrised, sequenced successor to the single-cycle opcode decoder. It fetches instructions through a valid/ready handshake and latches each into an internal instruction register. It then steps ALU, load/store and branch instructions through a small FSM, holding memory strobes until the data memory acknowledges. It sits between the instruction fetch path and the datapath (register file, ALU, data memory, PC), and adds variable memory latency, a memory timeout and illegal-opcode detection with a sticky fault.

---
 rtl/multi_cycle_control.sv | 160 ++++++++++++++++
 tb/tb_multi_cycle_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Sequenced controller: fetches instructions over valid/ready into an IR and
// steps ALU, load/store and branch instructions, with memory timeout and sticky fault.
module multi_cycle_control #(
   parameter int unsigned IW           = 9,
   parameter int unsigned OPW          = 3,
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           init,
   input  logic           instr_valid,
   output logic           instr_ready,
   input  logic [IW-1:0]  instruction,
   input  logic           mem_ack,
   output logic [OPW-1:0] OP,
   output logic           writeEnable,
   output logic           memRead,
   output logic           memWrite,
   output logic           branch,
   output logic           ALUSrc,
   output logic           MemToReg,
   output logic           pc_en,
   output logic           busy,
   output logic           fault
);

   localparam int unsigned CW = $clog2(MEM_WAIT_MAX + 1);

   localparam logic [OPW-1:0] OP_LW = OPW'(5);
   localparam logic [OPW-1:0] OP_SW = OPW'(6);
   localparam logic [OPW-1:0] OP_BR = OPW'(7);
   localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_WAIT_MAX - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_BR    = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ir_q, ir_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            fault_q, fault_d;

   logic [OPW-1:0]  fetch_op;
   logic            fetch_illegal;
   logic            ir_is_lw;

   assign fetch_op      = instruction[IW-1 -: OPW];
   // Any bit above the low three makes the opcode illegal; empty for OPW == 3.
   assign fetch_illegal = |(fetch_op >> 3);
   assign ir_is_lw      = (ir_q[IW-1 -: OPW] == OP_LW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: begin
            if (instr_valid) begin
               ir_d  = instruction;
               cnt_d = '0;
               if (fetch_illegal)
                  state_d = S_FAULT;
               else if (fetch_op == OP_BR)
                  state_d = S_BR;
               else if (fetch_op == OP_LW || fetch_op == OP_SW)
                  state_d = S_MEM;
               else
                  state_d = S_EXEC;
            end
         end
         S_EXEC:  state_d = S_FETCH;
         S_BR:    state_d = S_FETCH;
         S_MEM: begin
            if (mem_ack)
               state_d = S_FETCH;
            else if (cnt_q == CNT_LAST)
               state_d = S_FAULT;
            else
               cnt_d = cnt_q + CW'(1);
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
      if (init) begin
         state_d = S_IDLE;
         ir_d    = ir_q;
         cnt_d   = '0;
      end
      fault_d = (state_d == S_FAULT);
   end

   always_comb begin
      instr_ready = 1'b0;
      writeEnable = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      branch      = 1'b0;
      ALUSrc      = 1'b0;
      MemToReg    = 1'b0;
      pc_en       = 1'b0;
      unique case (state_q)
         S_FETCH: instr_ready = 1'b1;
         S_EXEC: begin
            writeEnable = 1'b1;
            pc_en       = 1'b1;
         end
         S_BR: begin
            branch = 1'b1;
            pc_en  = 1'b1;
         end
         S_MEM: begin
            ALUSrc = 1'b1;
            pc_en  = mem_ack;
            if (ir_is_lw) begin
               memRead     = 1'b1;
               MemToReg    = 1'b1;
               writeEnable = mem_ack;
            end else begin
               memWrite = 1'b1;
            end
         end
         default: ;
      endcase
      if (init) begin
         instr_ready = 1'b0;
         writeEnable = 1'b0;
         memRead     = 1'b0;
         memWrite    = 1'b0;
         branch      = 1'b0;
         ALUSrc      = 1'b0;
         MemToReg    = 1'b0;
         pc_en       = 1'b0;
      end
   end

   assign OP    = ir_q[IW-1 -: OPW];
   assign busy  = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_BR);
   assign fault = fault_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control (IW=9, OPW=4, MEM_WAIT_MAX=15).
module tb_multi_cycle_control;

   localparam int unsigned IW  = 9;
   localparam int unsigned OPW = 4;

   // Output vector: {instr_ready, writeEnable, memRead, memWrite, branch,
   //                 ALUSrc, MemToReg, pc_en, busy, fault}
   localparam logic [9:0] NONE = 10'h000;
   localparam logic [9:0] RDY  = 10'h200;
   localparam logic [9:0] WE   = 10'h100;
   localparam logic [9:0] MR   = 10'h080;
   localparam logic [9:0] MW   = 10'h040;
   localparam logic [9:0] BRN  = 10'h020;
   localparam logic [9:0] AS   = 10'h010;
   localparam logic [9:0] MTR  = 10'h008;
   localparam logic [9:0] PC   = 10'h004;
   localparam logic [9:0] BSY  = 10'h002;
   localparam logic [9:0] FLT  = 10'h001;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           init;
   logic           instr_valid;
   logic           instr_ready;
   logic [IW-1:0]  instruction;
   logic           mem_ack;
   logic [OPW-1:0] OP;
   logic           writeEnable, memRead, memWrite, branch;
   logic           ALUSrc, MemToReg, pc_en, busy, fault;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   multi_cycle_control #(
      .IW(IW),
      .OPW(OPW),
      .MEM_WAIT_MAX(15)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .init(init),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instruction(instruction),
      .mem_ack(mem_ack),
      .OP(OP),
      .writeEnable(writeEnable),
      .memRead(memRead),
      .memWrite(memWrite),
      .branch(branch),
      .ALUSrc(ALUSrc),
      .MemToReg(MemToReg),
      .pc_en(pc_en),
      .busy(busy),
      .fault(fault)
   );

   always #5 clk = ~clk;

   function automatic logic [IW-1:0] mk(input logic [OPW-1:0] op, input logic [4:0] low);
      return {op, low};
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [9:0] exp);
      chk(tag, {6'd0, instr_ready, writeEnable, memRead, memWrite, branch,
                ALUSrc, MemToReg, pc_en, busy, fault}, {6'd0, exp});
   endtask

   task automatic chk_op(input string tag, input logic [OPW-1:0] exp);
      chk(tag, {{(16-OPW){1'b0}}, OP}, {{(16-OPW){1'b0}}, exp});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; init = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
      instruction = '0;
      #1;
      chk_outs("reset_outs", NONE);
      chk_op("reset_op", 4'd0);

      @(negedge clk); rst_n = 1'b1; #1;
      chk_outs("idle", NONE);

      // ADD
      @(negedge clk); instr_valid = 1'b1; instruction = mk(4'd4, 5'h15); #1;
      chk_outs("add_fetch", RDY);
      @(negedge clk); instr_valid = 1'b0; #1;
      chk_outs("add_exec", WE | PC | BSY);
      chk_op("add_op", 4'd4);
      @(negedge clk); mem_ack = 1'b1; #1;
      chk_outs("stray_ack_fetch", RDY);
      @(negedge clk); mem_ack = 1'b0; #1;
      chk_outs("fetch_after_stray", RDY);
      chk_op("op_after_stray", 4'd4);

      // LW, ack in 3rd MEM cycle; valid during MEM must be ignored
      instr_valid = 1'b1; instruction = mk(4'd5, 5'h03); #1;
      chk_outs("lw_fetch", RDY);
      @(negedge clk); instr_valid = 1'b0; #1;
      chk_outs("lw_mem1", MR | AS | MTR | BSY);
      @(negedge clk); instr_valid = 1'b1; instruction = mk(4'd4, 5'h00); #1;
      chk_outs("lw_mem2", MR | AS | MTR | BSY);
      @(negedge clk); instr_valid = 1'b0; mem_ack = 1'b1; #1;
      chk_outs("lw_mem3_ack", WE | MR | AS | MTR | PC | BSY);
      @(negedge clk); mem_ack = 1'b0; #1;
      chk_outs("lw_back_fetch", RDY);
      chk_op("lw_op_held", 4'd5);

      // SW, ack in 1st MEM cycle
      instr_valid = 1'b1; instruction = mk(4'd6, 5'h0a); #1;
      @(negedge clk); instr_valid = 1'b0; mem_ack = 1'b1; #1;
      chk_outs("sw_mem1_ack", MW | AS | PC | BSY);
      @(negedge clk); mem_ack = 1'b0; #1;
      chk_outs("sw_back_fetch", RDY);

      // BR
      instr_valid = 1'b1; instruction = mk(4'd7, 5'h1f); #1;
      @(negedge clk); instr_valid = 1'b0; #1;
      chk_outs("br_cycle", BRN | PC | BSY);
      chk_op("br_op", 4'd7);
      @(negedge clk); #1;
      chk_outs("br_back_fetch", RDY);

      // LW with no ack: 15 MEM cycles then FAULT
      instr_valid = 1'b1; instruction = mk(4'd5, 5'h01); #1;
      @(negedge clk); instr_valid = 1'b0; #1;
      for (int i = 0; i < 15; i++) begin
         chk_outs($sformatf("lw_wait_%0d", i + 1), MR | AS | MTR | BSY);
         @(negedge clk); #1;
      end
      chk_outs("timeout_fault", FLT);
      instr_valid = 1'b1; instruction = mk(4'd4, 5'h00);
      @(negedge clk); instr_valid = 1'b0; init = 1'b1; #1;
      chk_outs("fault_hold_init_cycle", FLT);
      chk_op("fault_ir_held", 4'd5);
      @(negedge clk); init = 1'b0; #1;
      chk_outs("init_to_idle", NONE);
      @(negedge clk); #1;
      chk_outs("idle_to_fetch", RDY);

      // Illegal opcode 9
      instr_valid = 1'b1; instruction = mk(4'd9, 5'h00); #1;
      @(negedge clk); instr_valid = 1'b0; #1;
      chk_outs("illegal_fault", FLT);
      chk_op("illegal_op", 4'd9);
      @(negedge clk); init = 1'b1; #1;
      @(negedge clk); init = 1'b0; #1;
      chk_outs("illegal_cleared", NONE);
      @(negedge clk); #1;
      chk_outs("fetch_after_illegal", RDY);

      // init during LW MEM: strobes low in init cycle, no writeback
      instr_valid = 1'b1; instruction = mk(4'd5, 5'h02); #1;
      @(negedge clk); instr_valid = 1'b0; init = 1'b1; mem_ack = 1'b1; #1;
      chk_outs("init_mid_mem", BSY);
      @(negedge clk); init = 1'b0; mem_ack = 1'b0; #1;
      chk_outs("init_mid_mem_idle", NONE);
      @(negedge clk); #1;
      chk_outs("fetch_after_init", RDY);

      // rst_n low in 2nd MEM cycle of SW
      instr_valid = 1'b1; instruction = mk(4'd6, 5'h04); #1;
      @(negedge clk); instr_valid = 1'b0; #1;
      chk_outs("sw2_mem1", MW | AS | BSY);
      @(negedge clk); rst_n = 1'b0; #1;
      chk_outs("reset_mid_sw", NONE);
      chk_op("reset_mid_sw_op", 4'd0);
      @(negedge clk); rst_n = 1'b1; #1;
      chk_outs("post_reset_idle", NONE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
